// File: rtl/boson_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// boson_pkg : shared types for the Boson CMOS video capture block.
// Rev 1.0
// ----------------------------------------------------------------------------
package boson_pkg;

    localparam int PIX_W = 16;
    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        ACTIVE = 2'd2,
        DROP   = 2'd3
    } state_t;

    typedef struct packed {
        logic             sof;
        logic             eol;
        logic [PIX_W-1:0] data;
    } fifo_word_t;

    typedef struct packed {
        logic             clk;
        logic             vsync;
        logic             hsync;
        logic             valid;
        logic [PIX_W-1:0] dq;
    } cam_bus_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/boson_cap_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// boson_cap_fifo : synchronous first-word-fall-through FIFO, 2**AW words.
// Rev 1.0
// ----------------------------------------------------------------------------
module boson_cap_fifo
    import boson_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_en,
    input  fifo_word_t wr_word,
    input  logic       rd_en,
    output fifo_word_t rd_word,
    output logic       full,
    output logic       empty
);

    localparam int DEPTH = 2 ** AW;

    fifo_word_t      mem [DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic            do_wr, do_rd;

    // A read in the same cycle frees a slot, so a write to a full FIFO may proceed.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_word;
        end
    end

    assign rd_word = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/boson_video_capture.sv
`default_nettype none
// ----------------------------------------------------------------------------
// boson_video_capture : oversamples the Boson CMOS bus, frames pixels with
// sof/eol markers and buffers them. Optional: BOSON_TESTPATTERN_EN. Rev 1.0
// ----------------------------------------------------------------------------
module boson_video_capture
    import boson_pkg::*;
#(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 256,
    parameter int FIFO_AW  = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
`ifdef BOSON_TESTPATTERN_EN
    input  logic             test_en,
`endif
    input  logic             cmos_clk,
    input  logic             cmos_vsync,
    input  logic             cmos_hsync,
    input  logic             cmos_valid,
    input  logic [PIX_W-1:0] cmos_dq,
    output logic [PIX_W-1:0] out_data,
    output logic             out_sof,
    output logic             out_eol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_done,
    output logic             line_err,
    output logic             frame_err,
    output logic             overflow,
    input  logic             err_clr
);

    localparam logic [CNT_W-1:0] H_CNT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_CNT  = CNT_W'(V_ACTIVE);

    cam_bus_t         sync1_q, sync1_d, sync2_q, sync2_d, align_q, align_d;
    logic             clk_prev_q, clk_prev_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
    logic             sof_pend_q, sof_pend_d;
    logic             vsync_prev_q, vsync_prev_d, valid_prev_q, valid_prev_d;
    logic             frame_done_q, frame_done_d;
    logic             line_err_q, line_err_d, frame_err_q, frame_err_d, overflow_q, overflow_d;
    logic             strobe, vsync_rise, vsync_fall, line_end;
    logic             wr_req, wr_ok, line_err_set, frame_err_set, overflow_set;
    logic             fifo_full, fifo_empty;
    logic [PIX_W-1:0] pix_data;
    fifo_word_t       wr_word, rd_word;

    // Whole bus travels through the same depth so the strobe lines up with its data.
    always_comb begin
        sync1_d    = {cmos_clk, cmos_vsync, cmos_hsync, cmos_valid, cmos_dq};
        sync2_d    = sync1_q;
        align_d    = sync2_q;
        clk_prev_d = align_q.clk;
        strobe     = align_q.clk & ~clk_prev_q;
        vsync_rise = align_q.vsync & ~vsync_prev_q;
        vsync_fall = ~align_q.vsync & vsync_prev_q;
        line_end   = ~align_q.valid & valid_prev_q;
        wr_ok      = !fifo_full || (out_ready && !fifo_empty);
`ifdef BOSON_TESTPATTERN_EN
        pix_data   = test_en ? {line_cnt_q[7:0], pix_cnt_q[7:0]} : align_q.dq;
`else
        pix_data   = align_q.dq;
`endif
    end

    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        sof_pend_d    = sof_pend_q;
        vsync_prev_d  = vsync_prev_q;
        valid_prev_d  = valid_prev_q;
        frame_done_d  = 1'b0;
        line_err_set  = 1'b0;
        frame_err_set = 1'b0;
        wr_req        = 1'b0;
        wr_word       = '{sof: sof_pend_q, eol: (pix_cnt_q == H_LAST), data: pix_data};
        if (strobe) begin
            vsync_prev_d = align_q.vsync;
            valid_prev_d = align_q.valid;
            case (state_q)
                IDLE: if (enable && !align_q.vsync) state_d = ARM;
                ARM: begin
                    if (vsync_rise) begin
                        state_d    = ACTIVE;
                        line_cnt_d = '0;
                        pix_cnt_d  = '0;
                        sof_pend_d = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (vsync_fall) begin
                        frame_err_set = (line_cnt_q != V_CNT);
                        frame_done_d  = 1'b1;
                        state_d       = enable ? ARM : IDLE;
                    end else if (align_q.valid) begin
                        if (pix_cnt_q < H_CNT) begin
                            wr_req     = 1'b1;
                            sof_pend_d = 1'b0;
                        end else begin
                            line_err_set = 1'b1;
                        end
                        pix_cnt_d = sat_inc(pix_cnt_q);
                    end else if (line_end) begin
                        line_err_set = (pix_cnt_q != H_CNT);
                        line_cnt_d   = sat_inc(line_cnt_q);
                        pix_cnt_d    = '0;
                    end else if (!align_q.hsync) begin
                        pix_cnt_d = '0;
                    end
                end
                DROP: if (vsync_fall) state_d = enable ? ARM : IDLE;
                default: state_d = IDLE;
            endcase
        end
        // A lost pixel abandons the rest of the frame rather than emit a gapped one.
        overflow_set = wr_req && !wr_ok;
        if (overflow_set) state_d = DROP;
        line_err_d  = line_err_set  | (line_err_q  & ~err_clr);
        frame_err_d = frame_err_set | (frame_err_q & ~err_clr);
        overflow_d  = overflow_set  | (overflow_q  & ~err_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            align_q      <= '0;
            clk_prev_q   <= 1'b0;
            state_q      <= IDLE;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            sof_pend_q   <= 1'b0;
            vsync_prev_q <= 1'b0;
            valid_prev_q <= 1'b0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            align_q      <= align_d;
            clk_prev_q   <= clk_prev_d;
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            sof_pend_q   <= sof_pend_d;
            vsync_prev_q <= vsync_prev_d;
            valid_prev_q <= valid_prev_d;
            frame_done_q <= frame_done_d;
            line_err_q   <= line_err_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
        end
    end

    boson_cap_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_req && wr_ok),
        .wr_word (wr_word),
        .rd_en   (out_ready),
        .rd_word (rd_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_data   = rd_word.data;
    assign out_sof    = rd_word.sof;
    assign out_eol    = rd_word.eol;
    assign out_valid  = ~fifo_empty;
    assign frame_done = frame_done_q;
    assign line_err   = line_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_boson_video_capture.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_boson_video_capture : scoreboard bench for boson_video_capture on a
// reduced 8x6 frame. Rev 1.0
// ----------------------------------------------------------------------------
module tb_boson_video_capture;

    localparam int HA = 8;
    localparam int VA = 6;
    localparam int AW = 5;

    logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
    logic        cmos_clk = 1'b0, cmos_vsync = 1'b0, cmos_hsync = 1'b1, cmos_valid = 1'b0;
    logic [15:0] cmos_dq = '0;
    logic [15:0] out_data;
    logic        out_sof, out_eol, out_valid, out_ready = 1'b0;
    logic        frame_done, line_err, frame_err, overflow, err_clr = 1'b0;
    bit          tp_on = 1'b0;
`ifdef BOSON_TESTPATTERN_EN
    logic        test_en = 1'b0;
`endif

    always #5  clk = ~clk;
    always #21 cmos_clk = ~cmos_clk;

    boson_video_capture #(
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .FIFO_AW  (AW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
`ifdef BOSON_TESTPATTERN_EN
        .test_en    (test_en),
`endif
        .cmos_clk   (cmos_clk),
        .cmos_vsync (cmos_vsync),
        .cmos_hsync (cmos_hsync),
        .cmos_valid (cmos_valid),
        .cmos_dq    (cmos_dq),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .line_err   (line_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .err_clr    (err_clr)
    );

    int          n_checks = 0, n_fail = 0;
    logic [17:0] sb_q[$];
    logic [17:0] exp_w;
    int          done_cnt = 0, sof_cnt = 0, eol_cnt = 0, done0 = 0;
    bit          discard = 1'b0, push_en = 1'b0, first_pix = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (frame_done) done_cnt++;
            if (out_valid && out_ready) begin
                if (out_sof) sof_cnt++;
                if (out_eol) eol_cnt++;
                if (!discard) begin
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", sb_q.size(), 1);
                    end else begin
                        exp_w = sb_q.pop_front();
                        check("word", {out_sof, out_eol, out_data}, exp_w);
                    end
                end
            end
        end
    end

    task automatic cam(input logic vs, input logic hs, input logic vl, input logic [15:0] d);
        @(negedge cmos_clk);
        cmos_vsync = vs;
        cmos_hsync = hs;
        cmos_valid = vl;
        cmos_dq    = d;
    endtask

    task automatic blank(input int n);
        repeat (n) cam(1'b0, 1'b1, 1'b0, 16'h0);
    endtask

    task automatic send_line(input int li, input int npix);
        cam(1'b1, 1'b0, 1'b0, 16'h0);
        cam(1'b1, 1'b1, 1'b0, 16'h0);
        for (int p = 0; p < npix; p++) begin
            logic [15:0] d;
            logic [15:0] d_exp;
            d     = 16'($urandom);
            d_exp = d;
            if (tp_on) d_exp = {li[7:0], p[7:0]};
            if (push_en && p < HA) begin
                sb_q.push_back({first_pix, (p == HA - 1), d_exp});
                first_pix = 1'b0;
            end
            cam(1'b1, 1'b1, 1'b1, d);
        end
        cam(1'b1, 1'b1, 1'b0, 16'h0);
        cam(1'b1, 1'b1, 1'b0, 16'h0);
    endtask

    task automatic send_frame(input int nlines, input int odd_line, input int odd_len,
                              input bit capture, input int en_off_line);
        push_en   = capture;
        first_pix = 1'b1;
        cam(1'b1, 1'b1, 1'b0, 16'h0);
        cam(1'b1, 1'b1, 1'b0, 16'h0);
        for (int l = 0; l < nlines; l++) begin
            if (l == en_off_line) enable = 1'b0;
            send_line(l, (l == odd_line) ? odd_len : HA);
        end
        blank(8);
        push_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((sb_q.size() != 0 || out_valid) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check(tag, sb_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic restart_counts();
        done0   = done_cnt;
        sof_cnt = 0;
        eol_cnt = 0;
    endtask

    initial begin
        out_ready = 1'b1;
        enable    = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sof", out_sof, 0);
        check("rst_out_eol", out_eol, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_line_err", line_err, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overflow", overflow, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        blank(6);

        // nominal: two full frames
        restart_counts();
        send_frame(VA, -1, 0, 1'b1, -1);
        send_frame(VA, -1, 0, 1'b1, -1);
        drain("t1_drain");
        check("t1_frame_done", done_cnt - done0, 2);
        check("t1_sof", sof_cnt, 2);
        check("t1_eol", eol_cnt, 2 * VA);
        check("t1_line_err", line_err, 0);
        check("t1_frame_err", frame_err, 0);
        check("t1_overflow", overflow, 0);

        // short line, then long line, then short frame
        restart_counts();
        send_frame(VA, 2, HA - 1, 1'b1, -1);
        drain("t3_drain");
        check("t3_line_err", line_err, 1);
        check("t3_frame_err", frame_err, 0);
        check("t3_eol", eol_cnt, VA - 1);
        pulse_clr();
        check("t3_clr_line_err", line_err, 0);
        send_frame(VA, 1, HA + 2, 1'b1, -1);
        drain("t3b_drain");
        check("t3b_line_err", line_err, 1);
        pulse_clr();
        restart_counts();
        send_frame(VA - 1, -1, 0, 1'b1, -1);
        drain("t3c_drain");
        check("t3c_frame_err", frame_err, 1);
        check("t3c_line_err", line_err, 0);
        check("t3c_frame_done", done_cnt - done0, 1);
        pulse_clr();
        check("t3c_clr_frame_err", frame_err, 0);

        // backpressure overflow
        restart_counts();
        discard = 1'b1;
        fork
            send_frame(VA, -1, 0, 1'b0, -1);
            begin
                @(posedge clk); #1 out_ready = 1'b0;
                repeat (300) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("t2_drain");
        discard = 1'b0;
        check("t2_overflow", overflow, 1);
        check("t2_no_frame_done", done_cnt - done0, 0);
        pulse_clr();
        check("t2_clr_overflow", overflow, 0);
        restart_counts();
        send_frame(VA, -1, 0, 1'b1, -1);
        drain("t2b_drain");
        check("t2b_sof", sof_cnt, 1);
        check("t2b_frame_done", done_cnt - done0, 1);
        check("t2b_overflow", overflow, 0);

        // reset mid-frame
        discard = 1'b1;
        fork
            send_frame(VA, -1, 0, 1'b0, -1);
            begin
                repeat (180) @(posedge clk);
                #1 reset_n = 1'b0;
                repeat (3) @(posedge clk);
                #1 reset_n = 1'b1;
                discard = 1'b0;
                restart_counts();
                @(negedge clk);
                check("t4_out_valid", out_valid, 0);
                check("t4_out_data", out_data, 0);
            end
        join
        check("t4_no_frame_done", done_cnt - done0, 0);
        send_frame(VA, -1, 0, 1'b1, -1);
        drain("t4_drain");
        check("t4_sof", sof_cnt, 1);
        check("t4_frame_done", done_cnt - done0, 1);

        // enable dropped mid-frame
        restart_counts();
        send_frame(VA, -1, 0, 1'b1, 2);
        drain("t5_drain");
        check("t5_eol", eol_cnt, VA);
        check("t5_frame_done", done_cnt - done0, 1);
        restart_counts();
        send_frame(VA, -1, 0, 1'b0, -1);
        repeat (50) @(negedge clk);
        check("t5_idle_no_done", done_cnt - done0, 0);
        check("t5_idle_no_words", sof_cnt + eol_cnt, 0);

`ifdef BOSON_TESTPATTERN_EN
        enable  = 1'b1;
        test_en = 1'b1;
        tp_on   = 1'b1;
        blank(4);
        restart_counts();
        send_frame(VA, -1, 0, 1'b1, -1);
        drain("t6_drain");
        check("t6_frame_done", done_cnt - done0, 1);
        test_en = 1'b0;
        tp_on   = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
